fft_butterfly_pipe: RTL and testbench

- Parametrised, fixed-point radix-2 butterfly for the FFT datapath. Successor to the fixed FP16 butterfly.
- Generalised data/twiddle widths; per-transaction DIT/DIF mode, forward/inverse, and optional 1-bit scaling; rounding, saturation and overflow reporting.
- Fully pipelined, fixed 4-cycle latency, valid/ready on both sides. Sits between the FFT stage memory read and write-back.

---
 rtl/fft_butterfly_pipe.sv | 181 ++++++++++++++++++
 tb/tb_fft_butterfly_pipe.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/fft_butterfly_pipe.sv
// Radix-2 fixed-point FFT butterfly, DIT or DIF per transaction, with conjugate
// twiddle for inverse transforms, optional 1-bit scaling and saturation. 4-stage pipeline.
module fft_butterfly_pipe #(
  parameter int W    = 16,
  parameter int TW   = 16,
  parameter int TAGW = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic signed [W-1:0]    ar,
  input  logic signed [W-1:0]    ai,
  input  logic signed [W-1:0]    br,
  input  logic signed [W-1:0]    bi,
  input  logic signed [TW-1:0]   wr,
  input  logic signed [TW-1:0]   wi,
  input  logic                   dif,
  input  logic                   inv,
  input  logic                   scale,
  input  logic [TAGW-1:0]        in_tag,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic signed [W-1:0]    xr,
  output logic signed [W-1:0]    xi,
  output logic signed [W-1:0]    yr,
  output logic signed [W-1:0]    yi,
  output logic [TAGW-1:0]        out_tag,
  output logic                   ovf,
  output logic                   ovf_sticky,
  input  logic                   clr
);

  localparam int PW = W + TW + 2;
  localparam logic signed [PW:0]  RND  = {{PW{1'b0}}, 1'b1} << (TW - 2);
  localparam logic signed [W+2:0] ONE  = {{(W+2){1'b0}}, 1'b1};
  localparam logic signed [W+2:0] VMAX = {4'b0000, {(W-1){1'b1}}};
  localparam logic signed [W+2:0] VMIN = {4'b1111, {(W-1){1'b0}}};

  // Handshake: a transfer happens on a rising edge where valid && ready. The
  // pipeline only stalls when the output holds data the sink refuses; then every
  // stage freezes and in_ready drops in the same cycle.
  logic stall, adv;
  assign stall    = out_valid && !out_ready;
  assign adv      = !stall;
  assign in_ready = adv;

  function automatic logic signed [W+2:0] rnd(input logic signed [PW:0] p);
    logic signed [PW:0] t;
    t = (p + RND) >>> (TW - 1);
    return t[W+2:0];
  endfunction

  // Returns {clipped, value}: optional halving with round-half-up, then clip to W bits.
  function automatic logic [W:0] fin(input logic signed [W+2:0] v, input logic sc);
    logic signed [W+2:0] t;
    t = sc ? ((v + ONE) >>> 1) : v;
    if (t > VMAX)      fin = {1'b1, VMAX[W-1:0]};
    else if (t < VMIN) fin = {1'b1, VMIN[W-1:0]};
    else               fin = {1'b0, t[W-1:0]};
  endfunction

  // Stage 1: input capture
  logic                  s1_valid, s1_dif, s1_inv, s1_scale;
  logic signed [W-1:0]   s1_ar, s1_ai, s1_br, s1_bi;
  logic signed [TW-1:0]  s1_wr, s1_wi;
  logic [TAGW-1:0]       s1_tag;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid <= 1'b0; s1_dif <= 1'b0; s1_inv <= 1'b0; s1_scale <= 1'b0;
      s1_ar <= '0; s1_ai <= '0; s1_br <= '0; s1_bi <= '0;
      s1_wr <= '0; s1_wi <= '0; s1_tag <= '0;
    end else if (adv) begin
      s1_valid <= in_valid; s1_dif <= dif; s1_inv <= inv; s1_scale <= scale;
      s1_ar <= ar; s1_ai <= ai; s1_br <= br; s1_bi <= bi;
      s1_wr <= wr; s1_wi <= wi; s1_tag <= in_tag;
    end
  end

  // Stage 2: the multiplier operand is B for DIT and A-B for DIF; u is the pass-through term.
  logic signed [TW:0]   wr_e, wci;
  logic signed [W:0]    ar_e, ai_e, br_e, bi_e, m_r, m_i, u_r, u_i;
  logic signed [PW-1:0] p_rr, p_ii, p_ri, p_ir;

  always_comb begin
    wr_e = {s1_wr[TW-1], s1_wr};
    wci  = {s1_wi[TW-1], s1_wi};
    if (s1_inv) wci = -wci;
    ar_e = {s1_ar[W-1], s1_ar};
    ai_e = {s1_ai[W-1], s1_ai};
    br_e = {s1_br[W-1], s1_br};
    bi_e = {s1_bi[W-1], s1_bi};
    m_r  = s1_dif ? (ar_e - br_e) : br_e;
    m_i  = s1_dif ? (ai_e - bi_e) : bi_e;
    u_r  = s1_dif ? (ar_e + br_e) : ar_e;
    u_i  = s1_dif ? (ai_e + bi_e) : ai_e;
    p_rr = PW'(m_r) * PW'(wr_e);
    p_ii = PW'(m_i) * PW'(wci);
    p_ri = PW'(m_r) * PW'(wci);
    p_ir = PW'(m_i) * PW'(wr_e);
  end

  logic                 s2_valid, s2_dif, s2_scale;
  logic signed [W:0]    s2_ur, s2_ui;
  logic signed [PW-1:0] s2_prr, s2_pii, s2_pri, s2_pir;
  logic [TAGW-1:0]      s2_tag;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s2_valid <= 1'b0; s2_dif <= 1'b0; s2_scale <= 1'b0; s2_tag <= '0;
      s2_ur <= '0; s2_ui <= '0;
      s2_prr <= '0; s2_pii <= '0; s2_pri <= '0; s2_pir <= '0;
    end else if (adv) begin
      s2_valid <= s1_valid; s2_dif <= s1_dif; s2_scale <= s1_scale; s2_tag <= s1_tag;
      s2_ur <= u_r; s2_ui <= u_i;
      s2_prr <= p_rr; s2_pii <= p_ii; s2_pri <= p_ri; s2_pir <= p_ir;
    end
  end

  // Stage 3: complex product combine and rounding
  logic signed [PW:0] zs_r, zs_i;

  always_comb begin
    zs_r = (PW+1)'(s2_prr) - (PW+1)'(s2_pii);
    zs_i = (PW+1)'(s2_pri) + (PW+1)'(s2_pir);
  end

  logic                 s3_valid, s3_dif, s3_scale;
  logic signed [W+2:0]  s3_ur, s3_ui, s3_zr, s3_zi;
  logic [TAGW-1:0]      s3_tag;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s3_valid <= 1'b0; s3_dif <= 1'b0; s3_scale <= 1'b0; s3_tag <= '0;
      s3_ur <= '0; s3_ui <= '0; s3_zr <= '0; s3_zi <= '0;
    end else if (adv) begin
      s3_valid <= s2_valid; s3_dif <= s2_dif; s3_scale <= s2_scale; s3_tag <= s2_tag;
      s3_ur <= {{2{s2_ur[W]}}, s2_ur};
      s3_ui <= {{2{s2_ui[W]}}, s2_ui};
      s3_zr <= rnd(zs_r);
      s3_zi <= rnd(zs_i);
    end
  end

  // Stage 4: DIT add/subtract (DIF already has X and Y), then scale and saturate.
  logic signed [W+2:0] fx_r, fx_i, fy_r, fy_i;
  logic [W:0]          rx_r, rx_i, ry_r, ry_i;

  always_comb begin
    fx_r = s3_dif ? s3_ur : (s3_ur + s3_zr);
    fx_i = s3_dif ? s3_ui : (s3_ui + s3_zi);
    fy_r = s3_dif ? s3_zr : (s3_ur - s3_zr);
    fy_i = s3_dif ? s3_zi : (s3_ui - s3_zi);
    rx_r = fin(fx_r, s3_scale);
    rx_i = fin(fx_i, s3_scale);
    ry_r = fin(fy_r, s3_scale);
    ry_i = fin(fy_i, s3_scale);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0; out_tag <= '0; ovf <= 1'b0;
      xr <= '0; xi <= '0; yr <= '0; yi <= '0;
    end else if (adv) begin
      out_valid <= s3_valid;
      out_tag   <= s3_tag;
      ovf       <= rx_r[W] | rx_i[W] | ry_r[W] | ry_i[W];
      xr <= rx_r[W-1:0]; xi <= rx_i[W-1:0];
      yr <= ry_r[W-1:0]; yi <= ry_i[W-1:0];
    end
  end

  // A set on the output handshake takes priority over a coincident clr.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                           ovf_sticky <= 1'b0;
    else if (out_valid && out_ready && ovf) ovf_sticky <= 1'b1;
    else if (clr)                       ovf_sticky <= 1'b0;
  end

endmodule

// File: tb/tb_fft_butterfly_pipe.sv
// Directed bench for fft_butterfly_pipe: one task per scenario with inline checks
// against hand-computed values, ending in a single summary line.
module tb_fft_butterfly_pipe;
  localparam int W = 16, TW = 16, TAGW = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic in_valid = 1'b0, in_ready;
  logic [W-1:0] ar = '0, ai = '0, br = '0, bi = '0;
  logic [TW-1:0] wr = '0, wi = '0;
  logic dif = 1'b0, inv = 1'b0, scale = 1'b0, clr = 1'b0;
  logic [TAGW-1:0] in_tag = '0, out_tag;
  logic out_valid, out_ready = 1'b1;
  logic [W-1:0] xr, xi, yr, yi;
  logic ovf, ovf_sticky;

  int errors = 0;
  int checks = 0;

  // Streaming vectors with twiddle = -1 exactly (0x8000, 0): DIT gives X=A-B, Y=A+B;
  // DIF gives X=A+B, Y=B-A. Even tags are DIT, odd tags DIF.
  logic [15:0] st_ar [8] = '{16'h1000, 16'h1100, 16'h1200, 16'h1300, 16'h1400, 16'h1500, 16'h1600, 16'h1700};
  logic [15:0] st_bi [8] = '{16'h0000, 16'h0010, 16'h0020, 16'h0030, 16'h0040, 16'h0050, 16'h0060, 16'h0070};
  logic [15:0] ex_xr [8] = '{16'h0F00, 16'h1200, 16'h1100, 16'h1400, 16'h1300, 16'h1600, 16'h1500, 16'h1800};
  logic [15:0] ex_xi [8] = '{16'h0200, 16'h0210, 16'h01E0, 16'h0230, 16'h01C0, 16'h0250, 16'h01A0, 16'h0270};
  logic [15:0] ex_yr [8] = '{16'h1100, 16'hF000, 16'h1300, 16'hEE00, 16'h1500, 16'hEC00, 16'h1700, 16'hEA00};
  logic [15:0] ex_yi [8] = '{16'h0200, 16'hFE10, 16'h0220, 16'hFE30, 16'h0240, 16'hFE50, 16'h0260, 16'hFE70};

  always #5 clk = ~clk;

  fft_butterfly_pipe #(.W(W), .TW(TW), .TAGW(TAGW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .ar(ar), .ai(ai), .br(br), .bi(bi), .wr(wr), .wi(wi),
    .dif(dif), .inv(inv), .scale(scale), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .xr(xr), .xi(xi), .yr(yr), .yi(yi), .out_tag(out_tag),
    .ovf(ovf), .ovf_sticky(ovf_sticky), .clr(clr)
  );

  // Drives one transaction with out_ready high; reports outputs, edges from accept
  // to out_valid, and ovf_sticky after the output handshake.
  task automatic do_txn(input logic [15:0] a_r, a_i, b_r, b_i, w_r, w_i,
                        input logic m_dif, m_inv, m_scale, input logic [3:0] tag,
                        output logic [63:0] o_xy, output logic o_ovf,
                        output logic [3:0] o_tag, output logic o_sticky, output int lat);
    @(posedge clk); #1;
    ar = a_r; ai = a_i; br = b_r; bi = b_i; wr = w_r; wi = w_i;
    dif = m_dif; inv = m_inv; scale = m_scale; in_tag = tag;
    in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    @(negedge clk);
    while (!out_valid && lat < 20) begin
      @(posedge clk); lat++;
      @(negedge clk);
    end
    o_xy = {xr, xi, yr, yi}; o_ovf = ovf; o_tag = out_tag;
    @(posedge clk);
    @(negedge clk);
    o_sticky = ovf_sticky;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    checks++; if ({xr, xi, yr, yi} !== 64'h0) begin errors++; $display("FAIL reset_data: got %h expected 0", {xr, xi, yr, yi}); end
    checks++; if ({out_tag, ovf, ovf_sticky} !== 6'b0) begin errors++; $display("FAIL reset_flags: got %b expected 0", {out_tag, ovf, ovf_sticky}); end
    @(posedge clk); #1;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL post_reset_idle: got %b expected 0", out_valid); end
    end
  endtask

  task automatic test_dit_basic();
    logic [63:0] xy; logic o_ovf, st; logic [3:0] tg; int lat;
    do_txn(16'h1000, 16'h0000, 16'h2000, 16'h0000, 16'h7FFF, 16'h0000, 1'b0, 1'b0, 1'b0, 4'h3, xy, o_ovf, tg, st, lat);
    checks++; if (lat !== 4) begin errors++; $display("FAIL dit_latency: got %0d expected 4", lat); end
    checks++; if (xy !== 64'h3000_0000_F000_0000) begin errors++; $display("FAIL dit_basic: got %h expected 3000_0000_f000_0000", xy); end
    checks++; if (o_ovf !== 1'b0) begin errors++; $display("FAIL dit_basic_ovf: got %b expected 0", o_ovf); end
    checks++; if (tg !== 4'h3) begin errors++; $display("FAIL dit_basic_tag: got %h expected 3", tg); end
  endtask

  task automatic test_twiddle();
    logic [63:0] xy; logic o_ovf, st; logic [3:0] tg; int lat;
    do_txn(16'h0000, 16'h0000, 16'h2000, 16'h0000, 16'h0000, 16'h8000, 1'b0, 1'b0, 1'b0, 4'h5, xy, o_ovf, tg, st, lat);
    checks++; if (xy !== 64'h0000_E000_0000_2000) begin errors++; $display("FAIL twiddle_fwd: got %h expected 0000_e000_0000_2000", xy); end
    do_txn(16'h0000, 16'h0000, 16'h2000, 16'h0000, 16'h0000, 16'h8000, 1'b0, 1'b1, 1'b0, 4'h6, xy, o_ovf, tg, st, lat);
    checks++; if (xy !== 64'h0000_2000_0000_E000) begin errors++; $display("FAIL twiddle_inv: got %h expected 0000_2000_0000_e000", xy); end
    checks++; if (tg !== 4'h6) begin errors++; $display("FAIL twiddle_inv_tag: got %h expected 6", tg); end
  endtask

  task automatic test_saturation();
    logic [63:0] xy; logic o_ovf, st; logic [3:0] tg; int lat;
    do_txn(16'h7000, 16'h0000, 16'h7000, 16'h0000, 16'h7FFF, 16'h0000, 1'b0, 1'b0, 1'b0, 4'h1, xy, o_ovf, tg, st, lat);
    checks++; if (xy !== 64'h7FFF_0000_0001_0000) begin errors++; $display("FAIL sat_value: got %h expected 7fff_0000_0001_0000", xy); end
    checks++; if (o_ovf !== 1'b1) begin errors++; $display("FAIL sat_ovf: got %b expected 1", o_ovf); end
    checks++; if (st !== 1'b1) begin errors++; $display("FAIL sat_sticky: got %b expected 1", st); end
    do_txn(16'h7000, 16'h0000, 16'h7000, 16'h0000, 16'h7FFF, 16'h0000, 1'b0, 1'b0, 1'b1, 4'h2, xy, o_ovf, tg, st, lat);
    checks++; if (xy !== 64'h7000_0000_0001_0000) begin errors++; $display("FAIL scale_value: got %h expected 7000_0000_0001_0000", xy); end
    checks++; if (o_ovf !== 1'b0) begin errors++; $display("FAIL scale_ovf: got %b expected 0", o_ovf); end
    checks++; if (st !== 1'b1) begin errors++; $display("FAIL sticky_holds: got %b expected 1", st); end
    @(posedge clk); #1; clr = 1'b1;
    @(posedge clk); #1; clr = 1'b0;
    @(negedge clk);
    checks++; if (ovf_sticky !== 1'b0) begin errors++; $display("FAIL sticky_clr: got %b expected 0", ovf_sticky); end
    clr = 1'b1;
    do_txn(16'h7000, 16'h0000, 16'h7000, 16'h0000, 16'h7FFF, 16'h0000, 1'b0, 1'b0, 1'b0, 4'h4, xy, o_ovf, tg, st, lat);
    clr = 1'b0;
    checks++; if (st !== 1'b1) begin errors++; $display("FAIL clr_vs_set: got %b expected 1", st); end
  endtask

  task automatic test_dif();
    logic [63:0] xy; logic o_ovf, st; logic [3:0] tg; int lat;
    do_txn(16'h1000, 16'h0800, 16'h0400, 16'h0000, 16'h7FFF, 16'h0000, 1'b1, 1'b0, 1'b0, 4'h9, xy, o_ovf, tg, st, lat);
    checks++; if (lat !== 4) begin errors++; $display("FAIL dif_latency: got %0d expected 4", lat); end
    checks++; if (xy !== 64'h1400_0800_0C00_0800) begin errors++; $display("FAIL dif_value: got %h expected 1400_0800_0c00_0800", xy); end
    checks++; if (o_ovf !== 1'b0) begin errors++; $display("FAIL dif_ovf: got %b expected 0", o_ovf); end
  endtask

  task automatic test_back_to_back();
    int n = 0, stall_cnt = 0;
    out_ready = 1'b1;
    fork
      begin : driver
        int k = 0, guard = 0;
        logic rdy;
        @(posedge clk); #1;
        while (k < 8 && guard < 60) begin
          ar = st_ar[k]; ai = 16'h0200; br = 16'h0100; bi = st_bi[k];
          wr = 16'h8000; wi = 16'h0000; dif = k[0]; inv = 1'b0; scale = 1'b0;
          in_tag = k[3:0]; in_valid = 1'b1;
          @(negedge clk); rdy = in_ready;
          @(posedge clk); #1; guard++;
          if (rdy) k++;
        end
        in_valid = 1'b0;
      end
      begin : monitor
        int cyc = 0, hold = 0;
        logic dropped = 1'b0;
        logic [67:0] snap = '0;
        while (n < 8 && cyc < 60) begin
          @(negedge clk); cyc++;
          checks++; if (in_ready !== !(out_valid && !out_ready)) begin errors++; $display("FAIL stream_in_ready: got %b expected %b", in_ready, !(out_valid && !out_ready)); end
          if (out_valid && !out_ready) begin
            if (stall_cnt > 0) begin
              checks++; if ({out_tag, xr, xi, yr, yi} !== snap) begin errors++; $display("FAIL stall_stable: got %h expected %h", {out_tag, xr, xi, yr, yi}, snap); end
            end
            snap = {out_tag, xr, xi, yr, yi};
            stall_cnt++;
          end else if (out_valid) begin
            checks++; if (out_tag !== n[3:0]) begin errors++; $display("FAIL stream_tag: got %h expected %h", out_tag, n[3:0]); end
            checks++; if ({xr, xi, yr, yi} !== {ex_xr[n], ex_xi[n], ex_yr[n], ex_yi[n]}) begin
              errors++; $display("FAIL stream_data: got %h expected %h", {xr, xi, yr, yi}, {ex_xr[n], ex_xi[n], ex_yr[n], ex_yi[n]});
            end
            n++;
          end
          @(posedge clk); #1;
          if (n == 2 && !dropped) begin
            out_ready = 1'b0; hold = 3; dropped = 1'b1;
          end else if (hold > 0) begin
            hold--;
            if (hold == 0) out_ready = 1'b1;
          end
        end
      end
    join
    out_ready = 1'b1;
    checks++; if (n !== 8) begin errors++; $display("FAIL stream_count: got %0d expected 8", n); end
    checks++; if (stall_cnt !== 3) begin errors++; $display("FAIL stream_stall_cycles: got %0d expected 3", stall_cnt); end
  endtask

  task automatic test_async_reset();
    logic [63:0] xy; logic o_ovf, st; logic [3:0] tg; int lat, seen;
    @(negedge clk);
    checks++; if (ovf_sticky !== 1'b1) begin errors++; $display("FAIL pre_reset_sticky: got %b expected 1", ovf_sticky); end
    out_ready = 1'b1;
    @(posedge clk); #1;
    for (int k = 0; k < 3; k++) begin
      ar = st_ar[k]; ai = 16'h0200; br = 16'h0100; bi = st_bi[k];
      wr = 16'h8000; wi = 16'h0000; dif = 1'b0; in_tag = k[3:0]; in_valid = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    @(posedge clk); #3;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL pre_reset_valid: got %b expected 1", out_valid); end
    rst = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL async_out_valid: got %b expected 0", out_valid); end
    checks++; if (ovf_sticky !== 1'b0) begin errors++; $display("FAIL async_sticky: got %b expected 0", ovf_sticky); end
    checks++; if ({xr, xi, yr, yi} !== 64'h0) begin errors++; $display("FAIL async_data: got %h expected 0", {xr, xi, yr, yi}); end
    @(posedge clk); #1;
    rst = 1'b1;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL post_async_idle: got %0d valid cycles expected 0", seen); end
    do_txn(16'h1000, 16'h0000, 16'h2000, 16'h0000, 16'h7FFF, 16'h0000, 1'b0, 1'b0, 1'b0, 4'hA, xy, o_ovf, tg, st, lat);
    checks++; if (lat !== 4) begin errors++; $display("FAIL post_reset_latency: got %0d expected 4", lat); end
    checks++; if ({tg, xy} !== {4'hA, 64'h3000_0000_F000_0000}) begin errors++; $display("FAIL post_reset_data: got %h expected a_3000_0000_f000_0000", {tg, xy}); end
  endtask

  initial begin
    test_reset();
    test_dit_basic();
    test_twiddle();
    test_saturation();
    test_dif();
    test_back_to_back();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
